// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks long-latency loads, raises stalls and selects forwarding paths.
// Optional operand forwarding is compiled in when HAZARD_SCOREBOARD_FWD_EN is defined.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   src1,
   input  logic [ADDR_W-1:0]   src2,
   input  logic [ADDR_W-1:0]   src3,
   input  logic [2:0]          use_src,
   input  logic [ADDR_W-1:0]   exe_dest,
   input  logic                exe_wb_en,
   input  logic                exe_mem_r_en,
   input  logic [ADDR_W-1:0]   mem_dest,
   input  logic                mem_wb_en,
   input  logic                ld_issue,
   input  logic [ADDR_W-1:0]   ld_dest,
   input  logic                ld_done,
   input  logic [ADDR_W-1:0]   ld_done_dest,
   input  logic                flush,
   output logic                hazard,
   output logic [1:0]          fwd_sel1,
   output logic [1:0]          fwd_sel2,
   output logic [1:0]          fwd_sel3,
   output logic [NUM_REGS-1:0] pending,
   output logic [CNT_W-1:0]    stall_count
);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [NUM_REGS-1:0] issue_dec, done_dec;
   logic [CNT_W-1:0]    stall_count_q, stall_count_d;
   logic [ADDR_W-1:0]   src [3];
   logic [2:0]          pend_hit, exe_hit, mem_hit;

   assign src[0] = src1;
   assign src[1] = src2;
   assign src[2] = src3;

   // Decoding only indices below NUM_REGS drops out-of-range load addresses.
   always_comb begin
      issue_dec = '0;
      done_dec  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ld_issue && ld_dest == ADDR_W'(i))     issue_dec[i] = 1'b1;
         if (ld_done && ld_done_dest == ADDR_W'(i)) done_dec[i]  = 1'b1;
      end
   end

   always_comb begin
      pend_hit = '0;
      exe_hit  = '0;
      mem_hit  = '0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (use_src[k] && src[k] == ADDR_W'(i) && pending_q[i]) pend_hit[k] = 1'b1;
         end
         exe_hit[k] = use_src[k] && exe_wb_en && (src[k] == exe_dest);
         mem_hit[k] = use_src[k] && mem_wb_en && (src[k] == mem_dest);
      end
   end

`ifdef HAZARD_SCOREBOARD_FWD_EN
   function automatic logic [1:0] fwd_code(input logic from_exe, input logic from_mem);
      if (from_exe)      return 2'b01;
      else if (from_mem) return 2'b10;
      else               return 2'b00;
   endfunction

   always_comb begin
      hazard   = (|pend_hit) || (exe_mem_r_en && (|exe_hit));
      fwd_sel1 = 2'b00;
      fwd_sel2 = 2'b00;
      fwd_sel3 = 2'b00;
      if (!hazard) begin
         fwd_sel1 = fwd_code(exe_hit[0], mem_hit[0]);
         fwd_sel2 = fwd_code(exe_hit[1], mem_hit[1]);
         fwd_sel3 = fwd_code(exe_hit[2], mem_hit[2]);
      end
   end
`else
   logic unused_load_flag;
   assign unused_load_flag = exe_mem_r_en;

   // Without bypass paths any in-flight producer must stall the consumer.
   always_comb begin
      hazard   = (|pend_hit) || (|exe_hit) || (|mem_hit);
      fwd_sel1 = 2'b00;
      fwd_sel2 = 2'b00;
      fwd_sel3 = 2'b00;
   end
`endif

   // Set is applied after clear so a same-register issue wins; flush beats both.
   always_comb begin
      pending_d = flush ? '0 : ((pending_q & ~done_dec) | issue_dec);
      stall_count_d = stall_count_q;
      if (hazard && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q     <= '0;
         stall_count_q <= '0;
      end else begin
         pending_q     <= pending_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign pending     = pending_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic vs a model.
// Instance a uses default parameters; instance b uses NUM_REGS=12, CNT_W=4.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] src1 = '0, src2 = '0, src3 = '0;
   logic [2:0] use_src = '0;
   logic [3:0] exe_dest = '0, mem_dest = '0, ld_dest = '0, ld_done_dest = '0;
   logic       exe_wb_en = 1'b0, exe_mem_r_en = 1'b0, mem_wb_en = 1'b0;
   logic       ld_issue = 1'b0, ld_done = 1'b0, flush = 1'b0;

   logic        hazard_a, hazard_b;
   logic [1:0]  fwd1_a, fwd2_a, fwd3_a, fwd1_b, fwd2_b, fwd3_b;
   logic [15:0] pending_a, stall_a;
   logic [11:0] pending_b;
   logic [3:0]  stall_b;

   int total = 0;
   int bad   = 0;

   bit [15:0]   pend_a_m, pend_b_m;
   int unsigned cnt_a_m, cnt_b_m;

   always #5 clk = ~clk;

   hazard_scoreboard u_dut_a (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src3(src3), .use_src(use_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .ld_issue(ld_issue), .ld_dest(ld_dest),
      .ld_done(ld_done), .ld_done_dest(ld_done_dest), .flush(flush), .hazard(hazard_a),
      .fwd_sel1(fwd1_a), .fwd_sel2(fwd2_a), .fwd_sel3(fwd3_a), .pending(pending_a),
      .stall_count(stall_a)
   );

   hazard_scoreboard #(.NUM_REGS(12), .ADDR_W(4), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src3(src3), .use_src(use_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .ld_issue(ld_issue), .ld_dest(ld_dest),
      .ld_done(ld_done), .ld_done_dest(ld_done_dest), .flush(flush), .hazard(hazard_b),
      .fwd_sel1(fwd1_b), .fwd_sel2(fwd2_b), .fwd_sel3(fwd3_b), .pending(pending_b),
      .stall_count(stall_b)
   );

   // Reference: expected stall and operand selects from the current inputs and a model scoreboard.
   function automatic void model_eval(input int nregs, input bit [15:0] pend,
                                      output bit hz, output bit [5:0] fwd);
      int s[3];
      bit ex, me;
      bit [1:0] f[3];
      s[0] = int'(src1); s[1] = int'(src2); s[2] = int'(src3);
      hz = 1'b0;
      for (int k = 0; k < 3; k++) begin
         f[k] = 2'b00;
         if (use_src[k]) begin
            ex = exe_wb_en && s[k] == int'(exe_dest);
            me = mem_wb_en && s[k] == int'(mem_dest);
            if (s[k] < nregs && pend[s[k]]) hz = 1'b1;
`ifdef HAZARD_SCOREBOARD_FWD_EN
            if (ex && exe_mem_r_en) hz = 1'b1;
            f[k] = ex ? 2'b01 : (me ? 2'b10 : 2'b00);
`else
            if (ex || me) hz = 1'b1;
`endif
         end
      end
      fwd = hz ? 6'd0 : {f[2], f[1], f[0]};
   endfunction

   function automatic bit [15:0] next_pend(input int nregs, input bit [15:0] pend);
      bit [15:0] p;
      if (flush) return 16'd0;
      p = pend;
      if (ld_done && int'(ld_done_dest) < nregs) p[ld_done_dest] = 1'b0;
      if (ld_issue && int'(ld_dest) < nregs)     p[ld_dest] = 1'b1;
      return p;
   endfunction

   task automatic tick();
      bit hz;
      bit [5:0] f;
      if (rst) begin
         model_eval(16, pend_a_m, hz, f);
         if (hz && cnt_a_m < 65535) cnt_a_m++;
         model_eval(12, pend_b_m, hz, f);
         if (hz && cnt_b_m < 15) cnt_b_m++;
         pend_a_m = next_pend(16, pend_a_m);
         pend_b_m = next_pend(12, pend_b_m);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      src1 = '0; src2 = '0; src3 = '0; use_src = '0;
      exe_dest = '0; mem_dest = '0; ld_dest = '0; ld_done_dest = '0;
      exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
      ld_issue = 1'b0; ld_done = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      clear_inputs();
      pend_a_m = '0; pend_b_m = '0; cnt_a_m = 0; cnt_b_m = 0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      use_src = 3'b111;
      #2;
      total++;
      if (pending_a !== 16'd0 || pending_b !== 12'd0) begin
         bad++; $display("FAIL reset_pending got a=%h b=%h want 0", pending_a, pending_b);
      end
      total++;
      if (stall_a !== 16'd0 || stall_b !== 4'd0) begin
         bad++; $display("FAIL reset_stall got a=%0d b=%0d want 0", stall_a, stall_b);
      end
      total++;
      if (hazard_a !== 1'b0 || {fwd3_a, fwd2_a, fwd1_a} !== 6'd0) begin
         bad++; $display("FAIL reset_outputs got hazard=%b fwd=%h want 0/0", hazard_a,
                         {fwd3_a, fwd2_a, fwd1_a});
      end
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      pend_a_m = '0; pend_b_m = '0; cnt_a_m = 0; cnt_b_m = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_stall();
      do_reset();
      ld_issue = 1'b1; ld_dest = 4'd5;
      @(negedge clk);
      total++;
      if (hazard_a !== 1'b0) begin
         bad++; $display("FAIL load_cycle0_hazard got %b want 0", hazard_a);
      end
      tick();
      ld_issue = 1'b0; src1 = 4'd5; use_src = 3'b001;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) begin ld_done = 1'b1; ld_done_dest = 4'd5; end
         @(negedge clk);
         total++;
         if (hazard_a !== 1'b1 || hazard_b !== 1'b1) begin
            bad++; $display("FAIL load_stall_c%0d got a=%b b=%b want 1", c, hazard_a, hazard_b);
         end
         tick();
      end
      ld_done = 1'b0;
      @(negedge clk);
      total++;
      if (hazard_a !== 1'b0 || pending_a !== 16'd0) begin
         bad++; $display("FAIL load_release got hazard=%b pending=%h want 0/0", hazard_a, pending_a);
      end
      total++;
      if (stall_a !== 16'd4 || stall_b !== 4'd4) begin
         bad++; $display("FAIL load_stall_count got a=%0d b=%0d want 4", stall_a, stall_b);
      end
      tick();
   endtask

   task automatic test_forwarding();
      bit [6:0] exp_raw, exp_lu, exp_mem;
`ifdef HAZARD_SCOREBOARD_FWD_EN
      exp_raw = {1'b0, 6'b00_01_01};
      exp_mem = {1'b0, 6'b00_10_10};
`else
      exp_raw = {1'b1, 6'd0};
      exp_mem = {1'b1, 6'd0};
`endif
      exp_lu = {1'b1, 6'd0};
      do_reset();
      src1 = 4'd3; src2 = 4'd3; src3 = 4'd9; use_src = 3'b011;
      exe_dest = 4'd3; exe_wb_en = 1'b1; mem_dest = 4'd3; mem_wb_en = 1'b1;
      exe_mem_r_en = 1'b0;
      @(negedge clk);
      total++;
      if ({hazard_a, fwd3_a, fwd2_a, fwd1_a} !== exp_raw) begin
         bad++; $display("FAIL fwd_exe got %b want %b", {hazard_a, fwd3_a, fwd2_a, fwd1_a}, exp_raw);
      end
      tick();
      exe_mem_r_en = 1'b1;
      @(negedge clk);
      total++;
      if ({hazard_a, fwd3_a, fwd2_a, fwd1_a} !== exp_lu) begin
         bad++; $display("FAIL fwd_load_use got %b want %b", {hazard_a, fwd3_a, fwd2_a, fwd1_a},
                         exp_lu);
      end
      tick();
      exe_mem_r_en = 1'b0; exe_dest = 4'd4;
      @(negedge clk);
      total++;
      if ({hazard_a, fwd3_a, fwd2_a, fwd1_a} !== exp_mem) begin
         bad++; $display("FAIL fwd_mem got %b want %b", {hazard_a, fwd3_a, fwd2_a, fwd1_a}, exp_mem);
      end
      tick();
   endtask

   task automatic test_set_wins_flush();
      do_reset();
      ld_issue = 1'b1; ld_dest = 4'd7; ld_done = 1'b1; ld_done_dest = 4'd7;
      tick();
      ld_issue = 1'b0; ld_done = 1'b0; src1 = 4'd7; use_src = 3'b001;
      @(negedge clk);
      total++;
      if (pending_a !== 16'h0080 || pending_b !== 12'h080) begin
         bad++; $display("FAIL set_wins got a=%h b=%h want 0080/080", pending_a, pending_b);
      end
      tick();
      flush = 1'b1; ld_issue = 1'b1; ld_dest = 4'd2;
      @(negedge clk);
      total++;
      if (hazard_a !== 1'b1) begin
         bad++; $display("FAIL flush_cycle_hazard got %b want 1", hazard_a);
      end
      tick();
      clear_inputs();
      @(negedge clk);
      total++;
      if (pending_a !== 16'd0 || pending_b !== 12'd0) begin
         bad++; $display("FAIL flush_clear got a=%h b=%h want 0", pending_a, pending_b);
      end
      total++;
      if (stall_a !== 16'd2) begin
         bad++; $display("FAIL flush_keeps_count got %0d want 2", stall_a);
      end
      tick();
   endtask

   task automatic test_out_of_range();
      do_reset();
      ld_issue = 1'b1; ld_dest = 4'd13;
      tick();
      ld_issue = 1'b0; src1 = 4'd13; use_src = 3'b001;
      @(negedge clk);
      total++;
      if (pending_a !== 16'h2000 || pending_b !== 12'd0) begin
         bad++; $display("FAIL range_pending got a=%h b=%h want 2000/000", pending_a, pending_b);
      end
      total++;
      if (hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
         bad++; $display("FAIL range_hazard got a=%b b=%b want 1/0", hazard_a, hazard_b);
      end
      tick();
   endtask

   task automatic test_saturation_async_reset();
      do_reset();
      ld_issue = 1'b1; ld_dest = 4'd9;
      tick();
      ld_issue = 1'b0; src1 = 4'd9; use_src = 3'b001;
      for (int c = 0; c < 20; c++) tick();
      @(negedge clk);
      total++;
      if (stall_b !== 4'd15 || stall_a !== 16'd20) begin
         bad++; $display("FAIL saturate got a=%0d b=%0d want 20/15", stall_a, stall_b);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (stall_a !== 16'd0 || stall_b !== 4'd0 || pending_a !== 16'd0 || pending_b !== 12'd0) begin
         bad++; $display("FAIL async_reset got stall=%0d/%0d pending=%h/%h want 0", stall_a,
                         stall_b, pending_a, pending_b);
      end
      total++;
      if (hazard_a !== 1'b0) begin
         bad++; $display("FAIL reset_discards_load got hazard=%b want 0", hazard_a);
      end
      pend_a_m = '0; pend_b_m = '0; cnt_a_m = 0; cnt_b_m = 0;
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      bit hz;
      bit [5:0] f;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         src1 = 4'($urandom_range(0, 15)); src2 = 4'($urandom_range(0, 15));
         src3 = 4'($urandom_range(0, 15)); use_src = 3'($urandom);
         exe_dest = 4'($urandom_range(0, 15)); mem_dest = 4'($urandom_range(0, 15));
         exe_wb_en = 1'($urandom); mem_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom);
         ld_issue = ($urandom_range(0, 4) == 0); ld_dest = 4'($urandom_range(0, 15));
         ld_done = ($urandom_range(0, 4) < 2); ld_done_dest = 4'($urandom_range(0, 15));
         flush = ($urandom_range(0, 31) == 0);
         @(negedge clk);
         model_eval(16, pend_a_m, hz, f);
         total++;
         if ({hazard_a, fwd3_a, fwd2_a, fwd1_a} !== {hz, f}) begin
            bad++; $display("FAIL rand_a_comb c=%0d got %b want %b", c,
                            {hazard_a, fwd3_a, fwd2_a, fwd1_a}, {hz, f});
         end
         model_eval(12, pend_b_m, hz, f);
         total++;
         if ({hazard_b, fwd3_b, fwd2_b, fwd1_b} !== {hz, f}) begin
            bad++; $display("FAIL rand_b_comb c=%0d got %b want %b", c,
                            {hazard_b, fwd3_b, fwd2_b, fwd1_b}, {hz, f});
         end
         total++;
         if (pending_a !== pend_a_m || pending_b !== pend_b_m[11:0]) begin
            bad++; $display("FAIL rand_pending c=%0d got %h/%h want %h/%h", c, pending_a,
                            pending_b, pend_a_m, pend_b_m[11:0]);
         end
         total++;
         if (stall_a !== 16'(cnt_a_m) || stall_b !== 4'(cnt_b_m)) begin
            bad++; $display("FAIL rand_stall c=%0d got %0d/%0d want %0d/%0d", c, stall_a,
                            stall_b, cnt_a_m, cnt_b_m);
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      pend_a_m = '0; pend_b_m = '0; cnt_a_m = 0; cnt_b_m = 0;
      test_reset();
      test_load_stall();
      test_forwarding();
      test_set_wins_flush();
      test_out_of_range();
      test_saturation_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
